// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer and its one-entry fetch buffer.
package fetch_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_STEP = 4;
  localparam int unsigned CNT_W   = 16;

  localparam logic [ADDR_W-1:0]  RESET_PC   = 8'h00;
  localparam logic [ADDR_W-1:0]  ALIGN_MASK = ~ADDR_W'(3);
  localparam logic [INSTR_W-1:0] ZERO_INSTR = '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_word_t;

  // Sequential successor; wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(PC_STEP);
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// One-entry valid/ready fetch register; load wins over flush.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               flush,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [ADDR_W-1:0]  in_pc,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc
);

  fetch_word_t word_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      valid  <= 1'b0;
    end else if (load) begin
      word_q <= '{instr: in_instr, pc: in_pc};
      valid  <= 1'b1;
    end else if (flush) begin
      valid  <= 1'b0;
    end
  end

  assign instr = word_q.instr;
  assign pc    = word_q.pc;

endmodule

// File: rtl/fetch_sequencer.sv
// PC, fetch FSM and delivered-word counter feeding a one-entry fetch buffer.
// Optional halt-on-zero-word behaviour is enabled by defining FETCH_HALT_ZERO_EN.
module fetch_sequencer
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               run_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_count
);

  state_t             state;
  state_t             state_next;
  logic [ADDR_W-1:0]  pc;
  logic [CNT_W-1:0]   count_q;
  logic               take;
  logic               zero_hit;
  logic               load;
  logic               halt_take;
  logic               flush;
  logic               handshake;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Redirect outranks every other transition; HALTED leaves only via redirect.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!redirect_valid && run_en) state_next = FETCH;
      FETCH: begin
        if (redirect_valid)  state_next = FETCH;
        else if (halt_take)  state_next = HALTED;
        else if (!run_en)    state_next = IDLE;
      end
      HALTED:  if (redirect_valid) state_next = run_en ? FETCH : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    take      = (state == FETCH) && (!out_valid || out_ready) && !redirect_valid;
`ifdef FETCH_HALT_ZERO_EN
    zero_hit  = (imem_instr == ZERO_INSTR);
`else
    zero_hit  = 1'b0;
`endif
    load      = take && !zero_hit;
    halt_take = take && zero_hit;
    handshake = out_valid && out_ready;
    flush     = redirect_valid || halt_take || (handshake && !load);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 pc <= RESET_PC;
    else if (redirect_valid) pc <= redirect_target & ALIGN_MASK;
    else if (load)           pc <= next_pc(pc);
  end

  // Counts every accepted word, including one accepted while being flushed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           count_q <= '0;
    else if (handshake && (count_q != '1)) count_q <= count_q + CNT_W'(1);
  end

`ifdef FETCH_HALT_ZERO_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) halted <= 1'b0;
    else     halted <= (state_next == HALTED);
  end
`else
  assign halted = 1'b0;
`endif

  assign imem_addr   = pc;
  assign fetch_count = count_q;

  fetch_buffer u_buffer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .flush    (flush),
    .in_instr (imem_instr),
    .in_pc    (pc),
    .valid    (out_valid),
    .instr    (out_instr),
    .pc       (out_pc)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer; expectations follow FETCH_HALT_ZERO_EN.
module tb_fetch_sequencer;

  typedef struct packed {
    logic [31:0] instr;
    logic [7:0]  pc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        run_en;
  logic [7:0]  imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [7:0]  redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [7:0]  out_pc;
  logic        halted;
  logic [15:0] fetch_count;

  int   tests;
  int   fails;
  exp_t exp_q[$];

  fetch_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .run_en          (run_en),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [7:0] a);
    case (a)
      8'h00:   return 32'h40000000;
      8'h04:   return 32'h41000010;
      8'h08:   return 32'h42000001;
      8'h0C:   return 32'h43000000;
      8'h10:   return 32'h30300000;
      8'h14:   return 32'h03320000;
      8'h18:   return 32'h50310010;
      8'h1C:   return 32'h00000000;
      default: return {8'hA5, 16'h0000, a};
    endcase
  endfunction

  assign imem_instr = rom_word(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] instr, input logic [7:0] pc);
    exp_q.push_back('{instr: instr, pc: pc});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted word must be the next expected one.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_word: got %h@%h, expected none", out_instr, out_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (out_instr !== e.instr || out_pc !== e.pc) begin
          fails++;
          $display("FAIL word: got %h@%h, expected %h@%h", out_instr, out_pc, e.instr, e.pc);
        end
      end
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    run_en = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 8'h00;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_count", 32'(fetch_count), 32'h0);
    check("rst_addr", 32'(imem_addr), 32'h00);
    check("rst_instr", out_instr, 32'h0);
    check("rst_pc", 32'(out_pc), 32'h0);
    rst = 1'b0;

    // Linear fetch of seven words
    push(32'h40000000, 8'h00); push(32'h41000010, 8'h04); push(32'h42000001, 8'h08);
    push(32'h43000000, 8'h0C); push(32'h30300000, 8'h10); push(32'h03320000, 8'h14);
    push(32'h50310010, 8'h18);
    run_en = 1'b1;
    out_ready = 1'b1;
    step();
    check("lin_valid_fetch_state", 32'(out_valid), 32'h0);
    step();
    check("lin_valid_first", 32'(out_valid), 32'h1);
    check("lin_pc_first", 32'(out_pc), 32'h00);
    repeat (5) step();
    run_en = 1'b0;
    repeat (3) step();
    check("lin_count", 32'(fetch_count), 32'd7);
    check("lin_addr", 32'(imem_addr), 32'h1C);
    check("lin_idle_valid", 32'(out_valid), 32'h0);

    // Backpressure while 42000001@08 is held
    push(32'h40000000, 8'h00); push(32'h41000010, 8'h04);
    push(32'h42000001, 8'h08); push(32'h43000000, 8'h0C);
    redirect_valid = 1'b1;
    redirect_target = 8'h00;
    step();
    redirect_valid = 1'b0;
    run_en = 1'b1;
    out_ready = 1'b1;
    repeat (4) step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_valid", 32'(out_valid), 32'h1);
      check("bp_instr", out_instr, 32'h42000001);
      check("bp_pc", 32'(out_pc), 32'h08);
      check("bp_addr", 32'(imem_addr), 32'h0C);
    end
    out_ready = 1'b1;
    step();
    check("bp_release_pc", 32'(out_pc), 32'h0C);
    step();
    out_ready = 1'b0;

    // Redirect to 0x13 flushes the held 30300000@10
    redirect_valid = 1'b1;
    redirect_target = 8'h13;
    step();
    redirect_valid = 1'b0;
    check("rd_valid", 32'(out_valid), 32'h0);
    check("rd_addr", 32'(imem_addr), 32'h10);
    check("rd_count", 32'(fetch_count), 32'd11);
    push(32'h30300000, 8'h10); push(32'h03320000, 8'h14);
    out_ready = 1'b1;
    step();
    check("rd_refetch_pc", 32'(out_pc), 32'h10);
    check("rd_refetch_valid", 32'(out_valid), 32'h1);
    run_en = 1'b0;
    repeat (3) step();
    check("rd_count_after", 32'(fetch_count), 32'd13);
    check("rd_idle_valid", 32'(out_valid), 32'h0);

    // Wrap at the top of the ROM and counter saturation
    push(32'hA50000F8, 8'hF8); push(32'hA50000FC, 8'hFC); push(32'h40000000, 8'h00);
    redirect_valid = 1'b1;
    redirect_target = 8'hF8;
    run_en = 1'b1;
    step();
    redirect_valid = 1'b0;
    check("wrap_addr_f8", 32'(imem_addr), 32'hF8);
    step();
    force dut.count_q = 16'hFFFD;
    step();
    release dut.count_q;
    check("wrap_addr_fc", 32'(imem_addr), 32'hFC);
    step();
    check("wrap_addr_00", 32'(imem_addr), 32'h00);
    run_en = 1'b0;
    step();
    check("sat_reach", 32'(fetch_count), 32'hFFFF);
    repeat (2) step();
    check("sat_hold", 32'(fetch_count), 32'hFFFF);
    check("wrap_idle_valid", 32'(out_valid), 32'h0);

    // Zero word at 0x1C
    push(32'h03320000, 8'h14); push(32'h50310010, 8'h18);
`ifndef FETCH_HALT_ZERO_EN
    push(32'h00000000, 8'h1C);
`endif
    redirect_valid = 1'b1;
    redirect_target = 8'h14;
    run_en = 1'b1;
    step();
    redirect_valid = 1'b0;
    repeat (3) step();
    run_en = 1'b0;
    repeat (3) step();
    check("halt_valid", 32'(out_valid), 32'h0);
`ifdef FETCH_HALT_ZERO_EN
    check("halt_flag", 32'(halted), 32'h1);
    check("halt_addr", 32'(imem_addr), 32'h1C);
    push(32'h40000000, 8'h00);
    redirect_valid = 1'b1;
    redirect_target = 8'h00;
    run_en = 1'b1;
    step();
    redirect_valid = 1'b0;
    run_en = 1'b0;
    check("halt_exit_flag", 32'(halted), 32'h0);
    repeat (3) step();
    check("halt_resume_addr", 32'(imem_addr), 32'h04);
`else
    check("nohalt_flag", 32'(halted), 32'h0);
    check("nohalt_addr", 32'(imem_addr), 32'h20);
`endif

    // Asynchronous reset during backpressure
    redirect_valid = 1'b1;
    redirect_target = 8'h08;
    run_en = 1'b1;
    out_ready = 1'b0;
    step();
    redirect_valid = 1'b0;
    repeat (3) step();
    check("pre_rst_valid", 32'(out_valid), 32'h1);
    #3 rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'h0);
    check("arst_halted", 32'(halted), 32'h0);
    check("arst_count", 32'(fetch_count), 32'h0);
    check("arst_addr", 32'(imem_addr), 32'h00);
    check("arst_pc", 32'(out_pc), 32'h00);
    run_en = 1'b0;
    step();
    rst = 1'b0;
    repeat (2) step();
    check("arst_after_valid", 32'(out_valid), 32'h0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
